// File: rtl/cnt_div_param.sv
// Parametrised up/down modulo counter with runtime modulus, synchronous load,
// terminal-count pulse and a wrap-toggled divider output. Define CNT_SAT_EN for saturating mode.
module cnt_div_param #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tog
);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             tog_nxt;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  // Only used where they cannot over/underflow, so WIDTH bits suffice.
  assign count_inc = count + 1'b1;
  assign count_dec = count - 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    count_nxt = count;
    tc_nxt    = 1'b0;
    tog_nxt   = tog;

    if (load) begin
      count_nxt = (load_val > max_val) ? max_val : load_val;
    end else if (enable) begin
`ifdef CNT_SAT_EN
      if (up) begin
        if (count > max_val) begin
          count_nxt = max_val;
          tc_nxt    = 1'b1;
          tog_nxt   = ~tog;
        end else if (count != max_val) begin
          count_nxt = count_inc;
          if (count_inc == max_val) begin
            tc_nxt  = 1'b1;
            tog_nxt = ~tog;
          end
        end
      end else if (count != '0) begin
        count_nxt = count_dec;
        if (count_dec == '0) begin
          tc_nxt  = 1'b1;
          tog_nxt = ~tog;
        end
      end
`else
      if (up) begin
        // >= so a modulus lowered below the current count wraps immediately.
        if (count >= max_val) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
          tog_nxt   = ~tog;
        end else begin
          count_nxt = count_inc;
        end
      end else begin
        if (count == '0) begin
          count_nxt = max_val;
          tc_nxt    = 1'b1;
          tog_nxt   = ~tog;
        end else begin
          count_nxt = count_dec;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= RST_VAL;
      tc    <= 1'b0;
      tog   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      tog   <= tog_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_div_param.sv
// Self-checking bench for cnt_div_param: directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic reference model.
module tb_cnt_div_param;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         tog;

  int n_checks = 0;
  int n_fail = 0;

  int m_count = 0;
  bit m_tc = 0;
  bit m_tog = 0;
  bit seen_reset = 0;

  cnt_div_param #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .up(up),
    .load_val(load_val), .max_val(max_val), .count(count), .tc(tc), .tog(tog)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the counter rules in plain integer arithmetic.
  always @(posedge clk) begin
    int mv;
    mv = int'(max_val);
    if (reset) begin
      m_count <= 0; m_tc <= 0; m_tog <= 0; seen_reset <= 1;
    end else if (load) begin
      m_count <= (int'(load_val) > mv) ? mv : int'(load_val);
      m_tc <= 0;
    end else if (enable) begin
`ifdef CNT_SAT_EN
      if (up) begin
        if (m_count > mv) begin
          m_count <= mv; m_tc <= 1; m_tog <= !m_tog;
        end else if (m_count == mv) begin
          m_tc <= 0;
        end else begin
          m_count <= m_count + 1;
          m_tc <= (m_count + 1 == mv);
          if (m_count + 1 == mv) m_tog <= !m_tog;
        end
      end else begin
        if (m_count == 0) begin
          m_tc <= 0;
        end else begin
          m_count <= m_count - 1;
          m_tc <= (m_count == 1);
          if (m_count == 1) m_tog <= !m_tog;
        end
      end
`else
      if (up) begin
        if (m_count >= mv) begin
          m_count <= 0; m_tc <= 1; m_tog <= !m_tog;
        end else begin
          m_count <= m_count + 1; m_tc <= 0;
        end
      end else begin
        if (m_count == 0) begin
          m_count <= mv; m_tc <= 1; m_tog <= !m_tog;
        end else begin
          m_count <= m_count - 1; m_tc <= 0;
        end
      end
`endif
    end else begin
      m_tc <= 0;
    end
  end

  always @(negedge clk) begin
    if (seen_reset) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_tc", 32'(tc), 32'(m_tc));
      check("model_tog", 32'(tog), 32'(m_tog));
    end
  end

  task automatic step(input bit r, input bit ld, input bit en, input bit u,
                      input int lv, input int mv);
    reset = r; load = ld; enable = en; up = u;
    load_val = lv[W-1:0]; max_val = mv[W-1:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int c, input bit t, input bit g);
    check({name, "_count"}, 32'(count), 32'(c));
    check({name, "_tc"}, 32'(tc), 32'(t));
    check({name, "_tog"}, 32'(tog), 32'(g));
  endtask

  initial begin
    step(1, 0, 0, 1, 0, 0);
    expect_out("reset", 0, 0, 0);
`ifdef CNT_SAT_EN
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 1, 0, 3);
      expect_out("sat_up", (i < 3) ? i : 3, i == 3, i >= 3);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 0, 0, 3);
      expect_out("sat_dn", (i < 3) ? 3 - i : 0, i == 3, i < 3);
    end
    step(0, 1, 0, 1, 9, 9);
    step(0, 0, 1, 1, 0, 5);
    expect_out("sat_clamp", 5, 1, 1);
`else
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0, 0);
      expect_out("div2", 0, 1, (i % 2) == 0);
    end
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 1, 0, 9);
      expect_out("mod10", i % 10, i == 10, i == 10);
    end
    step(0, 0, 1, 0, 0, 5);
    expect_out("dn_wrap", 5, 1, 0);
    step(0, 0, 1, 0, 0, 5);
    expect_out("dn_4", 4, 0, 0);
    step(0, 0, 1, 0, 0, 5);
    expect_out("dn_3", 3, 0, 0);
    step(0, 1, 1, 1, 12, 9);
    expect_out("load_clamp", 9, 0, 0);
    step(0, 0, 1, 1, 12, 9);
    expect_out("load_wrap", 0, 1, 1);
    step(0, 1, 0, 1, 7, 9);
    expect_out("load7", 7, 0, 1);
    step(1, 1, 1, 1, 7, 9);
    expect_out("reset_prio", 0, 0, 0);
    step(0, 1, 0, 1, 4, 9);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 9);
      expect_out("hold", 4, 0, 0);
    end
    step(0, 1, 0, 1, 7, 9);
    step(0, 0, 1, 1, 0, 3);
    expect_out("max_lowered_up", 0, 1, 1);
    step(0, 1, 0, 1, 15, 15);
    step(0, 0, 1, 1, 0, 15);
    expect_out("full_up", 0, 1, 0);
    step(0, 0, 1, 0, 0, 15);
    expect_out("full_dn", 15, 1, 1);
    step(0, 1, 0, 0, 6, 9);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 2);
    expect_out("max_lowered_dn0", 0, 0, 1);
    step(0, 0, 1, 0, 0, 2);
    expect_out("max_lowered_dn", 2, 1, 0);
`endif
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, (i / 7) % 2 == 0,
           int'($urandom_range(0, 15)), (i % 50 < 5) ? 0 : int'((i / 25) % 16));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
